if_id_stage: RTL

Receiving end of the fetch interface: takes (pc, inst) pairs from the fetch stage and holds them in the IF/ID pipeline register. It presents them with MIPS field decode to the ID stage. Valid/ready handshake on both sides, with a one-entry skid buffer so that if_ready is purely registered. A flush input squashes wrong-path instructions after a taken branch or jump.

---
 rtl/if_id_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with a one-entry skid buffer and MIPS field decode.
// if_ready is a pure register output (~skid_valid), so fetch never sees a combinational path from ID.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [31:0] id_imm_sext,
  output logic [31:0] id_branch_target,
  output logic [31:0] id_jump_target,
  output logic [2:0]  id_class
);
  logic        main_valid, skid_valid, accept, consume, advance;
  logic [31:0] main_pc, main_inst, skid_pc, skid_inst, pc_plus4;
  assign if_ready = ~skid_valid;
  assign accept   = if_valid & if_ready & ~flush;
  assign consume  = main_valid & id_ready;
  assign advance  = ~main_valid | consume;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= PC_RESET;
      main_inst  <= NOP_INST;
      skid_pc    <= PC_RESET;
      skid_inst  <= NOP_INST;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (advance) begin
      main_valid <= skid_valid | accept;
      skid_valid <= skid_valid & accept;
      if (skid_valid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end else if (accept) begin
        main_pc   <= if_pc;
        main_inst <= if_inst;
      end
      if (skid_valid & accept) begin
        skid_pc   <= if_pc;
        skid_inst <= if_inst;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_pc    <= if_pc;
      skid_inst  <= if_inst;
    end
  // An empty stage presents a NOP at PC_RESET so decode never sees stale data
  assign id_valid         = main_valid;
  assign id_pc            = main_valid ? main_pc : PC_RESET;
  assign id_inst          = main_valid ? main_inst : NOP_INST;
  assign id_opcode        = id_inst[31:26];
  assign id_rs            = id_inst[25:21];
  assign id_rt            = id_inst[20:16];
  assign id_rd            = id_inst[15:11];
  assign id_shamt         = id_inst[10:6];
  assign id_funct         = id_inst[5:0];
  assign id_imm_sext      = {{16{id_inst[15]}}, id_inst[15:0]};
  assign pc_plus4         = id_pc + 32'd4;
  assign id_branch_target = pc_plus4 + {id_imm_sext[29:0], 2'b00};
  assign id_jump_target   = {pc_plus4[31:28], id_inst[25:0], 2'b00};
  assign id_class = (id_opcode == 6'h00)                          ? 3'd0 :
                    (id_opcode inside {6'h04, 6'h05})             ? 3'd1 :
                    (id_opcode inside {6'h02, 6'h03})             ? 3'd2 :
                    (id_opcode == 6'h23)                          ? 3'd3 :
                    (id_opcode == 6'h2B)                          ? 3'd4 :
                    (id_opcode inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F}) ? 3'd5 : 3'd7;
endmodule
